encoder_frame_ctrl: RTL and testbench

ENCODER_FRAME_CTRL -- requirements
Module: encoder_frame_ctrl

---
 rtl/encoder_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_encoder_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_frame_ctrl.sv
// Frame sequencer for a convolutional encoder: clears the shift register, streams
// FRAME_LEN info bits from upstream, flushes TAIL_LEN zero bits, then reports completion.
module encoder_frame_ctrl #(
  parameter int FRAME_LEN = 2048,
  parameter int TAIL_LEN  = 6
) (
  input  logic                         clk_sig,
  input  logic                         reset_sig,
  input  logic                         start_sig,
  input  logic                         abort_sig,
  input  logic                         in_valid_sig,
  output logic                         in_ready_sig,
  output logic                         enc_clr_sig,
  output logic                         enc_en_sig,
  output logic                         enc_sel_sig,
  output logic [$clog2(FRAME_LEN)-1:0] bit_cnt_sig,
  output logic                         busy_sig,
  output logic                         frame_done_sig,
  output logic [15:0]                  frame_cnt_sig,
  output logic [2:0]                   state_dbg
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_DATA = 3'd2,
    S_TAIL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q;
  logic [TW-1:0]   tail_cnt_q;
  logic [15:0]     frame_cnt_q;

  // Upstream handshake: a bit transfers on a rising edge where in_valid_sig and
  // in_ready_sig are both high; in_ready_sig is high only in DATA and never waits on
  // in_valid_sig, and upstream may hold or drop in_valid_sig freely (a stall).
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready_sig   = 1'b0;
    enc_clr_sig    = 1'b0;
    enc_en_sig     = 1'b0;
    enc_sel_sig    = 1'b0;
    busy_sig       = 1'b1;
    frame_done_sig = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_sig = 1'b0;
        if (start_sig) state_d = S_CLR;
      end
      S_CLR: begin
        enc_clr_sig = 1'b1;
        state_d     = abort_sig ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        in_ready_sig = 1'b1;
        // The encoder still shifts on an aborted handshake; only the count is dropped.
        enc_en_sig   = in_valid_sig;
        if (abort_sig)                                 state_d = S_IDLE;
        else if (in_valid_sig && bit_cnt_q == LAST_BIT) state_d = S_TAIL;
      end
      S_TAIL: begin
        enc_sel_sig = 1'b1;
        enc_en_sig  = 1'b1;
        if (abort_sig)                     state_d = S_IDLE;
        else if (tail_cnt_q == LAST_TAIL)  state_d = S_DONE;
      end
      S_DONE: begin
        frame_done_sig = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit index is only meaningful in DATA; every other state keeps it at zero.
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      bit_cnt_q <= '0;
    end else if (state_q == S_DATA) begin
      if (abort_sig)                  bit_cnt_q <= '0;
      else if (in_valid_sig) begin
        if (bit_cnt_q == LAST_BIT)    bit_cnt_q <= '0;
        else                          bit_cnt_q <= bit_cnt_q + BW'(1);
      end
    end else begin
      bit_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      tail_cnt_q <= '0;
    end else if (state_q == S_TAIL && !abort_sig && tail_cnt_q != LAST_TAIL) begin
      tail_cnt_q <= tail_cnt_q + TW'(1);
    end else begin
      tail_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      frame_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bit_cnt_sig   = bit_cnt_q;
  assign frame_cnt_sig = frame_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// Bench for encoder_frame_ctrl (FRAME_LEN=8, TAIL_LEN=2): a frame-progress model checked
// every cycle, directed frame scenarios with literal expectations, then random traffic.
module tb_encoder_frame_ctrl;

  localparam int FL = 8;
  localparam int TL = 2;

  // ---------------- clock / reset ----------------
  logic clk_sig = 1'b0;
  logic reset_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  logic       start_sig = 1'b0;
  logic       abort_sig = 1'b0;
  logic       in_valid_sig = 1'b0;
  logic       in_ready_sig, enc_clr_sig, enc_en_sig, enc_sel_sig;
  logic [2:0] bit_cnt_sig;
  logic       busy_sig, frame_done_sig;
  logic [15:0] frame_cnt_sig;
  logic [2:0] state_dbg;

  encoder_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL)) dut (
    .clk_sig        (clk_sig),
    .reset_sig      (reset_sig),
    .start_sig      (start_sig),
    .abort_sig      (abort_sig),
    .in_valid_sig   (in_valid_sig),
    .in_ready_sig   (in_ready_sig),
    .enc_clr_sig    (enc_clr_sig),
    .enc_en_sig     (enc_en_sig),
    .enc_sel_sig    (enc_sel_sig),
    .bit_cnt_sig    (bit_cnt_sig),
    .busy_sig       (busy_sig),
    .frame_done_sig (frame_done_sig),
    .frame_cnt_sig  (frame_cnt_sig),
    .state_dbg      (state_dbg)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is tracked as "bits accepted so far" and "tail bits emitted so far".
  bit m_active = 1'b0;
  bit m_first  = 1'b0;
  int m_bits   = 0;
  int m_tail   = 0;
  int m_fcnt   = 0;
  bit preload_req = 1'b0;
  logic [15:0] exp_q[$];

  always @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      m_active <= 1'b0;
      m_first  <= 1'b0;
      m_bits   <= 0;
      m_tail   <= 0;
      m_fcnt   <= 0;
    end else if (preload_req) begin
      m_fcnt <= 65535;
    end else if (!m_active) begin
      if (start_sig) begin
        m_active <= 1'b1;
        m_first  <= 1'b1;
        m_bits   <= 0;
        m_tail   <= 0;
      end
    end else if (m_first) begin
      if (abort_sig) m_active <= 1'b0;
      else           m_first  <= 1'b0;
    end else if (m_bits < FL) begin
      if (abort_sig)         m_active <= 1'b0;
      else if (in_valid_sig) m_bits   <= m_bits + 1;
    end else if (m_tail < TL) begin
      if (abort_sig) m_active <= 1'b0;
      else           m_tail   <= m_tail + 1;
    end else begin
      m_active <= 1'b0;
      m_fcnt   <= (m_fcnt + 1) % 65536;
      exp_q.push_back(16'((m_fcnt + 1) % 65536));
    end
  end

  logic e_clr, e_data, e_tail, e_done;
  assign e_clr  = m_active && m_first;
  assign e_data = m_active && !m_first && (m_bits < FL);
  assign e_tail = m_active && !m_first && (m_bits == FL) && (m_tail < TL);
  assign e_done = m_active && !m_first && (m_bits == FL) && (m_tail == TL);

  // ---------------- compare + monitor ----------------
  int cyc = 0, clr_cnt = 0, done_cnt = 0, en0_cnt = 0, en1_cnt = 0, stall_cnt = 0;
  int clr_last = 0, clr_prev = 0, done_cyc = 0;
  bit pend = 1'b0;

  always @(negedge clk_sig) begin
    chk("in_ready",   in_ready_sig,   e_data);
    chk("enc_clr",    enc_clr_sig,    e_clr);
    chk("enc_sel",    enc_sel_sig,    e_tail);
    chk("enc_en",     enc_en_sig,     (e_data && in_valid_sig) || e_tail);
    chk("busy",       busy_sig,       m_active);
    chk("frame_done", frame_done_sig, e_done);
    chk("bit_cnt",    bit_cnt_sig,    e_data ? m_bits : 0);
    chk("frame_cnt",  frame_cnt_sig,  m_fcnt);
    if (!reset_sig) begin
      exp_q.delete();
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() > 0) chk("frame_cnt_after_done", frame_cnt_sig, exp_q.pop_front());
        else                  chk("done_has_model_entry", 0, 1);
      end
      pend <= frame_done_sig;
    end
    cyc <= cyc + 1;
    if (enc_clr_sig) begin
      clr_cnt  <= clr_cnt + 1;
      clr_prev <= clr_last;
      clr_last <= cyc;
    end
    if (frame_done_sig) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (enc_en_sig && !enc_sel_sig) en0_cnt <= en0_cnt + 1;
    if (enc_en_sig && enc_sel_sig)  en1_cnt <= en1_cnt + 1;
    if (in_ready_sig && !in_valid_sig && bit_cnt_sig == 3'd4) stall_cnt <= stall_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sig);
      #1;
    end
  endtask

  int b_clr, b_done, b_en0, b_en1, b_stall;
  task automatic snap();
    b_clr = clr_cnt; b_done = done_cnt; b_en0 = en0_cnt; b_en1 = en1_cnt; b_stall = stall_cnt;
  endtask

  initial begin
    step(3);
    chk("reset_busy", busy_sig, 0);
    chk("reset_frame_cnt", frame_cnt_sig, 0);
    reset_sig = 1'b1;
    step(3);
    chk("idle_without_start", busy_sig, 0);

    // Continuous frame.
    snap();
    start_sig = 1'b1; in_valid_sig = 1'b1;
    step(1);
    start_sig = 1'b0;
    step(13);
    chk("t1_clr_cycles", clr_cnt - b_clr, 1);
    chk("t1_data_enables", en0_cnt - b_en0, 8);
    chk("t1_tail_enables", en1_cnt - b_en1, 2);
    chk("t1_done_offset", done_cyc - clr_last, 11);
    chk("t1_done_pulses", done_cnt - b_done, 1);
    chk("t1_frame_cnt", frame_cnt_sig, 1);

    // Three-cycle stall at bit 4.
    snap();
    start_sig = 1'b1;
    step(1);
    start_sig = 1'b0;
    step(5);
    chk("t2_bit_cnt_at_stall", bit_cnt_sig, 4);
    in_valid_sig = 1'b0;
    step(3);
    in_valid_sig = 1'b1;
    step(14);
    chk("t2_stall_cycles", stall_cnt - b_stall, 3);
    chk("t2_data_enables", en0_cnt - b_en0, 8);
    chk("t2_done_offset", done_cyc - clr_last, 14);
    chk("t2_frame_cnt", frame_cnt_sig, 2);

    // Abort in the first TAIL cycle.
    snap();
    start_sig = 1'b1;
    step(1);
    start_sig = 1'b0;
    step(9);
    chk("t3_in_tail", enc_sel_sig, 1);
    abort_sig = 1'b1;
    step(1);
    abort_sig = 1'b0;
    chk("t3_busy_after_abort", busy_sig, 0);
    chk("t3_ready_after_abort", in_ready_sig, 0);
    step(6);
    chk("t3_no_done", done_cnt - b_done, 0);
    chk("t3_frame_cnt", frame_cnt_sig, 2);

    // start held high: one frame, next CLR only after IDLE.
    snap();
    start_sig = 1'b1;
    step(12);
    step(2);
    #5;
    chk("t4_clr_count", clr_cnt - b_clr, 2);
    chk("t4_done_count", done_cnt - b_done, 1);
    chk("t4_clr_spacing", clr_last - clr_prev, 13);
    start_sig = 1'b0;
    abort_sig = 1'b1;
    step(1);
    abort_sig = 1'b0;
    chk("t4_frame_cnt", frame_cnt_sig, 3);

    // Asynchronous reset between edges at bit 5.
    snap();
    start_sig = 1'b1;
    step(1);
    start_sig = 1'b0;
    step(6);
    chk("t5_bit_cnt", bit_cnt_sig, 5);
    #2;
    reset_sig = 1'b0;
    #1;
    chk("t5_async_outputs",
        {in_ready_sig, enc_clr_sig, enc_en_sig, enc_sel_sig, busy_sig, frame_done_sig, bit_cnt_sig}, 0);
    chk("t5_async_frame_cnt", frame_cnt_sig, 0);
    step(2);
    #2;
    reset_sig = 1'b1;
    step(4);
    chk("t5_stays_idle", busy_sig, 0);
    chk("t5_no_done", done_cnt - b_done, 0);

    // Counter wrap. Reaching 65535 by running frames would take ~800k cycles, so the
    // count register is loaded directly while idle.
    @(negedge clk_sig);
    #1;
    force dut.frame_cnt_q = 16'hffff;
    preload_req = 1'b1;
    #1;
    release dut.frame_cnt_q;
    @(posedge clk_sig);
    #1;
    preload_req = 1'b0;
    chk("t6_preloaded", frame_cnt_sig, 16'hffff);
    start_sig = 1'b1;
    step(1);
    start_sig = 1'b0;
    step(11);
    chk("t6_in_done", frame_done_sig, 1);
    chk("t6_cnt_in_done", frame_cnt_sig, 16'hffff);
    step(1);
    chk("t6_wrapped", frame_cnt_sig, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      start_sig    = ($urandom_range(0, 3) == 0);
      in_valid_sig = ($urandom_range(0, 3) != 0);
      abort_sig    = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 200) == 0) begin
        reset_sig = 1'b0;
        step(1);
        reset_sig = 1'b1;
      end
      step(1);
    end
    start_sig = 1'b0; abort_sig = 1'b0; in_valid_sig = 1'b0;
    step(20);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("final_idle", busy_sig, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
